quantizer_share_arbiter: RTL and testbench

Shares one quantizer_top instance (find_max plus quantizer_part pipeline) between NUM_REQ requesters.
- Request side: round-robin grant, one beat (one IN_PARALLELISM x IN_SIZE tile) per grant.
- Tracking: a tag FIFO records which requester owns each in-flight tile.
- Response side: each quantized tile and its max_num are steered back to its owner, in issue order.
- Sits between producer lanes (e.g. per-head activation streams) and the shared quantizer.

---
 rtl/quantizer_share_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_quantizer_share_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quantizer_share_arbiter.sv
// quantizer_share_arbiter
//   Shares one quantizer pipeline (find_max + quantizer_part) between NUM_REQ
//   requesters. One tile is issued per grant, and grants rotate round-robin.
//   A tag FIFO records the owner of every in-flight tile. Each result is
//   steered back to its owner in issue order.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_data/valid/ready per-requester tile offer (requester r owns
//                        req_data[r*TILE +: TILE])
//   q_data_in*          tile towards the shared quantizer
//   q_data_out*, q_max_num  quantized tile and its max_num from the quantizer
//   resp_data/max_num   shared response bus (pass-through of quantizer output)
//   resp_valid/ready    per-requester response handshake (resp_valid one-hot)
//   outstanding         tiles issued and not yet returned
//   err_orphan          sticky: quantizer output seen with no tag in flight

// Per-requester handshake decode: this requester is selected on the issue
// side, on the response side, or on both.
module quantizer_share_arbiter_lane #(
  parameter int TAG_W = 1,
  parameter int IDX   = 0
) (
  input  logic             offer_vld,
  input  logic [TAG_W-1:0] offer_idx,
  input  logic             in_ready,
  input  logic             head_vld,
  input  logic [TAG_W-1:0] head_idx,
  input  logic             out_valid,
  output logic             req_ready,
  output logic             resp_valid
);
  assign req_ready  = offer_vld && (offer_idx == TAG_W'(IDX)) && in_ready;
  assign resp_valid = head_vld  && (head_idx  == TAG_W'(IDX)) && out_valid;
endmodule

module quantizer_share_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int IN_WIDTH       = 16,
  parameter int IN_SIZE        = 4,
  parameter int IN_PARALLELISM = 1,
  parameter int OUT_WIDTH      = 8,
  parameter int MAX_NUM_WIDTH  = IN_WIDTH,
  parameter int TAG_DEPTH      = 4,
  localparam int TILE  = IN_PARALLELISM * IN_SIZE,
  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int PTR_W = $clog2(TAG_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_WIDTH-1:0]      req_data [NUM_REQ*TILE],
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [IN_WIDTH-1:0]      q_data_in [TILE],
  output logic                     q_data_in_valid,
  input  logic                     q_data_in_ready,
  input  logic [OUT_WIDTH-1:0]     q_data_out [TILE],
  input  logic [MAX_NUM_WIDTH-1:0] q_max_num,
  input  logic                     q_data_out_valid,
  output logic                     q_data_out_ready,
  output logic [OUT_WIDTH-1:0]     resp_data [TILE],
  output logic [MAX_NUM_WIDTH-1:0] resp_max_num,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [CNT_W-1:0]         outstanding,
  output logic                     err_orphan
);

  typedef enum logic {ARB = 1'b0, HOLD = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [TAG_W-1:0]      rr_q, rr_d, hold_q, hold_d;
  logic [TAG_W-1:0]      grant, offer_idx, scan, head;
  logic                  found, can_issue, offer_vld, push, pop, empty, head_vld;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [TAG_W-1:0]      tag_q [TAG_DEPTH];
  logic                  err_q;
  logic [NUM_REQ-1:0][TILE-1:0][IN_WIDTH-1:0] req_tiles;

  // Regroup the flat request array into per-requester tiles.
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_tiles
    for (genvar t = 0; t < TILE; t++) begin : g_el
      assign req_tiles[r][t] = req_data[r*TILE + t];
    end
  end

  // Round-robin scan starting at rr_q.
  always_comb begin
    found = 1'b0;
    grant = rr_q;
    scan  = rr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = TAG_W'((int'(rr_q) + i) % NUM_REQ);
      if (!found && req_valid[scan]) begin
        found = 1'b1;
        grant = scan;
      end
    end
  end

  // Only the registered count is used here, so a pop in the same cycle
  // cannot free a slot for this issue. That keeps the path from response
  // ready to issue valid out of the combinational logic.
  assign can_issue = found && (count_q < CNT_W'(TAG_DEPTH));

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    hold_d    = hold_q;
    offer_idx = grant;
    offer_vld = 1'b0;
    push      = 1'b0;
    if (state_q == HOLD) begin
      offer_idx = hold_q;
      offer_vld = 1'b1;
    end else if (can_issue) begin
      offer_idx = grant;
      offer_vld = 1'b1;
    end
    // rst wins: no offer is visible while reset is applied.
    if (rst) offer_vld = 1'b0;
    if (offer_vld) begin
      if (q_data_in_ready) begin
        push    = 1'b1;
        rr_d    = (offer_idx == TAG_W'(NUM_REQ - 1)) ? '0 : offer_idx + 1'b1;
        state_d = ARB;
      end else begin
        hold_d  = offer_idx;
        state_d = HOLD;
      end
    end
  end

  for (genvar t = 0; t < TILE; t++) begin : g_qin
    assign q_data_in[t] = req_tiles[offer_idx][t];
    assign resp_data[t] = q_data_out[t];
  end
  assign q_data_in_valid = offer_vld;
  assign resp_max_num    = q_max_num;

  // Response side: the FIFO head owns whatever the quantizer presents.
  assign empty            = (count_q == '0);
  assign head             = tag_q[rd_ptr_q];
  assign head_vld         = !empty && !rst;
  assign q_data_out_ready = head_vld && resp_ready[head];
  assign pop              = q_data_out_valid && q_data_out_ready;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_lane
    quantizer_share_arbiter_lane #(.TAG_W(TAG_W), .IDX(r)) u_lane (
      .offer_vld  (offer_vld),
      .offer_idx  (offer_idx),
      .in_ready   (q_data_in_ready),
      .head_vld   (head_vld),
      .head_idx   (head),
      .out_valid  (q_data_out_valid),
      .req_ready  (req_ready[r]),
      .resp_valid (resp_valid[r])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB;
      rr_q     <= '0;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      if (q_data_out_valid && empty) err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push && !rst) tag_q[wr_ptr_q] <= offer_idx;
  end

  assign outstanding = count_q;
  assign err_orphan  = err_q;

endmodule

// File: tb/tb_quantizer_share_arbiter.sv
// Bench for quantizer_share_arbiter. A stand-in quantizer with a fixed
// latency is modelled here with queues. Each output element is the
// hi^lo byte of the input element. max_num is the largest FP16 magnitude.
module tb_quantizer_share_arbiter;
  localparam int N = 2, W = 16, TILE = 4, OW = 8, MW = 16, D = 4, LAT = 2;
  typedef logic [TILE-1:0][W-1:0] tile_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  req_data [N*TILE];
  logic [N-1:0]  req_valid, req_ready;
  logic [W-1:0]  q_data_in [TILE];
  logic          q_data_in_valid, q_data_in_ready;
  logic [OW-1:0] q_data_out [TILE];
  logic [MW-1:0] q_max_num;
  logic          q_data_out_valid, q_data_out_ready;
  logic [OW-1:0] resp_data [TILE];
  logic [MW-1:0] resp_max_num;
  logic [N-1:0]  resp_valid, resp_ready;
  logic [2:0]    outstanding;
  logic          err_orphan;

  quantizer_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .q_data_in(q_data_in), .q_data_in_valid(q_data_in_valid),
    .q_data_in_ready(q_data_in_ready),
    .q_data_out(q_data_out), .q_max_num(q_max_num),
    .q_data_out_valid(q_data_out_valid), .q_data_out_ready(q_data_out_ready),
    .resp_data(resp_data), .resp_max_num(resp_max_num),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  // Stand-in quantizer pipeline and reference model state.
  tile_t qp_tile[$];
  int    qp_rdy[$];
  int    m_tag[$];
  tile_t m_tile[$];
  int    m_rr, m_hold, cyc;
  bit    m_orph;
  // Requesters and knobs.
  bit    rv[N];
  tile_t rt[N];
  bit [N-1:0] en;
  int    pv, in_pct, out_pct[N];
  bit    qstall, force_orph;
  // Observations of the last step.
  logic [N-1:0] obs_rr, obs_rv;
  logic         obs_inv, obs_qor;
  logic [2:0]   obs_out, peak;
  logic [MW-1:0] last_max;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TILE*OW-1:0] fq_d(tile_t x);
    logic [TILE*OW-1:0] r;
    for (int t = 0; t < TILE; t++) r[t*OW +: OW] = x[t][15:8] ^ x[t][7:0];
    return r;
  endfunction

  function automatic logic [MW-1:0] fq_m(tile_t x);
    logic [MW-1:0] m = '0;
    for (int t = 0; t < TILE; t++)
      if ({1'b0, x[t][14:0]} > m) m = {1'b0, x[t][14:0]};
    return m;
  endfunction

  function automatic tile_t rand_tile();
    tile_t x;
    for (int t = 0; t < TILE; t++) x[t] = W'($urandom);
    return x;
  endfunction

  task automatic step();
    int g, k;
    bit ov, issue, popv, orph_set;
    tile_t qt, in_t;
    logic [TILE*OW-1:0] d, rd;
    logic [N-1:0] exp_rr, exp_rv;
    logic exp_qor;
    @(negedge clk);
    for (int r = 0; r < N; r++)
      if (!rv[r] && en[r] && int'($urandom_range(99)) < pv) begin
        rv[r] = 1'b1; rt[r] = rand_tile();
      end
    for (int r = 0; r < N; r++) begin
      req_valid[r] = rv[r];
      for (int t = 0; t < TILE; t++) req_data[r*TILE+t] = rt[r][t];
      resp_ready[r] = int'($urandom_range(99)) < out_pct[r];
    end
    q_data_in_ready = int'($urandom_range(99)) < in_pct;
    ov = force_orph || (qp_tile.size() > 0 && !qstall && cyc >= qp_rdy[0]);
    qt = (qp_tile.size() > 0) ? qp_tile[0] : '0;
    d  = fq_d(qt);
    for (int t = 0; t < TILE; t++) q_data_out[t] = d[t*OW +: OW];
    q_max_num = fq_m(qt);
    q_data_out_valid = ov;
    #1;
    obs_rr = req_ready; obs_inv = q_data_in_valid; obs_out = outstanding;
    obs_rv = resp_valid; obs_qor = q_data_out_ready;
    if (outstanding > peak) peak = outstanding;
    // Issue side: held offer first, else the first valid requester from rr.
    g = -1;
    if (m_hold >= 0) g = m_hold;
    else if (m_tag.size() < D)
      for (int i = 0; i < N; i++) begin
        k = (m_rr + i) % N;
        if (g < 0 && rv[k]) g = k;
      end
    chk("in_valid", q_data_in_valid, g >= 0);
    exp_rr = '0;
    if (g >= 0 && q_data_in_ready) exp_rr[g] = 1'b1;
    chk("req_ready", req_ready, exp_rr);
    if (g >= 0) begin
      for (int t = 0; t < TILE; t++) in_t[t] = q_data_in[t];
      chk("in_data", in_t, rt[g]);
    end
    // Response side: oldest issued tile owns the quantizer output.
    exp_rv = '0; exp_qor = 1'b0; orph_set = 1'b0;
    if (m_tag.size() > 0) begin
      if (ov) exp_rv[m_tag[0]] = 1'b1;
      exp_qor = resp_ready[m_tag[0]];
      if (ov) begin
        for (int t = 0; t < TILE; t++) rd[t*OW +: OW] = resp_data[t];
        chk("resp_data", rd, fq_d(m_tile[0]));
        chk("resp_max", resp_max_num, fq_m(m_tile[0]));
      end
    end else if (ov) orph_set = 1'b1;
    chk("resp_valid", resp_valid, exp_rv);
    chk("q_out_ready", q_data_out_ready, exp_qor);
    chk("outstanding", outstanding, m_tag.size());
    chk("err_orphan", err_orphan, m_orph);
    if (|resp_valid && q_data_out_ready) last_max = resp_max_num;
    issue = (g >= 0) && q_data_in_ready;
    popv  = ov && m_tag.size() > 0 && resp_ready[m_tag[0]];
    @(posedge clk);
    if (popv) begin
      void'(m_tag.pop_front()); void'(m_tile.pop_front());
      void'(qp_tile.pop_front()); void'(qp_rdy.pop_front());
    end
    if (issue) begin
      m_tag.push_back(g); m_tile.push_back(rt[g]);
      qp_tile.push_back(rt[g]); qp_rdy.push_back(cyc + LAT);
      m_rr = (g + 1) % N; m_hold = -1; rv[g] = 1'b0;
    end else if (g >= 0) m_hold = g;
    if (orph_set) m_orph = 1'b1;
    cyc++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    en = '0;
    for (int i = 0; i < 40 && (m_tag.size() > 0 || rv[0] || rv[1]); i++) step();
    chk("drained", m_tag.size() + int'(rv[0]) + int'(rv[1]), 0);
  endtask

  task automatic do_reset(int n);
    for (int r = 0; r < N; r++) rv[r] = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; req_valid = '1; q_data_in_ready = 1'b1;
      q_data_out_valid = 1'b1; resp_ready = '1;
      #1;
      chk("rst_in_valid", q_data_in_valid, 1'b0);
      chk("rst_req_ready", req_ready, '0);
      chk("rst_resp_valid", resp_valid, '0);
      chk("rst_out_ready", q_data_out_ready, 1'b0);
      @(posedge clk);
    end
    #1;
    rst = 1'b0; req_valid = '0; q_data_out_valid = 1'b0;
    m_tag.delete(); m_tile.delete(); qp_tile.delete(); qp_rdy.delete();
    m_rr = 0; m_hold = -1; m_orph = 1'b0;
    #1;
    chk("rst_outstanding", outstanding, 3'd0);
    chk("rst_err_orphan", err_orphan, 1'b0);
    chk("rst_idle_valid", q_data_in_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; resp_ready = '0; q_data_in_ready = 1'b0;
    q_data_out_valid = 1'b0; q_max_num = '0;
    for (int i = 0; i < N*TILE; i++) req_data[i] = '0;
    for (int t = 0; t < TILE; t++) q_data_out[t] = '0;
    cyc = 0; en = '0; pv = 0; in_pct = 100; out_pct[0] = 100; out_pct[1] = 100;
    qstall = 1'b0; force_orph = 1'b0; peak = '0; last_max = '0;
    do_reset(2);

    // Both requesters streaming: alternating grants, depth settles at 2.
    en = 2'b11; pv = 100; peak = '0;
    run(12);
    chk("t1_peak", peak, 3'd2);
    drain();

    // Lone requester 1 stalled by the quantizer, then released.
    pv = 0; rv[1] = 1'b1;
    rt[1] = {16'h3800, 16'hC400, 16'h4000, 16'h3C00};
    in_pct = 0;
    run(3);
    chk("t2_stall_valid", obs_inv, 1'b1);
    chk("t2_stall_ready", obs_rr, 2'b00);
    in_pct = 100;
    step();
    chk("t2_accept", obs_rr, 2'b10);
    run(3);
    chk("t2_max", last_max, 16'h4400);
    rv[0] = 1'b1; rv[1] = 1'b1; rt[0] = rand_tile(); rt[1] = rand_tile();
    step();
    chk("t2_next_grant", obs_rr, 2'b01);
    drain();

    // Quantizer output stalled until the tag FIFO is full.
    qstall = 1'b1; en = 2'b11; pv = 100;
    run(6);
    chk("t3_full", obs_out, 3'd4);
    chk("t3_no_offer", obs_inv, 1'b0);
    qstall = 1'b0;
    step();
    chk("t3_pop_no_issue", obs_inv, 1'b0);
    step();
    chk("t3_issue_after", obs_inv, 1'b1);
    drain();

    // Head-of-line block: requester 0 not ready, requester 1 queued behind.
    out_pct[0] = 0; pv = 0;
    rv[0] = 1'b1; rt[0] = rand_tile(); step();
    rv[1] = 1'b1; rt[1] = rand_tile(); step();
    run(4);
    chk("t4_hol_ready", obs_qor, 1'b0);
    chk("t4_hol_rv", obs_rv, 2'b01);
    out_pct[0] = 100;
    step();
    chk("t4_drain0", obs_rv, 2'b01);
    step();
    chk("t4_drain1", obs_rv, 2'b10);
    drain();

    // Orphan output with nothing in flight.
    force_orph = 1'b1; step(); force_orph = 1'b0;
    chk("t5_no_resp", obs_rv, 2'b00);
    run(2);
    chk("t5_sticky", err_orphan, 1'b1);

    // Random traffic.
    en = 2'b11; pv = 50; in_pct = 70; out_pct[0] = 70; out_pct[1] = 70;
    for (int i = 0; i < 300; i++) begin
      qstall = ($urandom_range(3) == 0);
      step();
    end
    qstall = 1'b0; out_pct[0] = 100; out_pct[1] = 100; in_pct = 100;
    drain();

    // Reset while holding an offer with two tags in flight.
    qstall = 1'b1; pv = 0;
    rv[0] = 1'b1; rt[0] = rand_tile(); step();
    rv[1] = 1'b1; rt[1] = rand_tile(); step();
    rv[0] = 1'b1; rt[0] = rand_tile(); in_pct = 0; step();
    chk("t6_pre_out", obs_out, 3'd2);
    qstall = 1'b0; in_pct = 100;
    do_reset(1);
    rv[0] = 1'b1; rv[1] = 1'b1; rt[0] = rand_tile(); rt[1] = rand_tile();
    step();
    chk("t6_first_grant", obs_rr, 2'b01);

    en = 2'b11; pv = 60; in_pct = 80; out_pct[0] = 80; out_pct[1] = 60;
    run(200);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
